// File: rtl/fb_rect_fill.sv
// rtl/fb_rect_fill.sv - MMIO rectangle-fill engine feeding the display_module write port
module fb_rect_fill #(
    parameter int         H_RES      = 640,
    parameter int         V_RES      = 480,
    parameter logic [3:0] FB_REGION  = 4'b0001,
    parameter logic [3:0] REG_REGION = 4'b0010
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] cpu_data,
    input  logic [31:0] cpu_waddr,
    input  logic        cpu_w_en,
    output logic        cpu_stall,
    output logic        busy,
    output logic        done,
    output logic [31:0] fb_data,
    output logic [31:0] fb_waddr,
    output logic        fb_w_en
);

    localparam logic [9:0]  H_RES_W = 10'(H_RES);
    localparam logic [9:0]  V_RES_W = 10'(V_RES);
    localparam logic [18:0] H_RES_A = 19'(H_RES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_FILL,
        S_DONE
    } state_t;

    state_t      state_q;

    // CPU-visible configuration
    logic [9:0]  x0_q, y0_q, w_q, h_q;
    logic [7:0]  colour_q;

    // Copies latched in SETUP so register writes cannot disturb a running fill
    logic [9:0]  fx0_q, cw_q, ch_q;
    logic [9:0]  col_q, row_q;
    logic [18:0] row_base_q;

    logic        done_q, fb_w_en_q;
    logic [31:0] fb_data_q, fb_waddr_q;

    logic        reg_wr, fb_wr, start;
    logic [9:0]  x_rem_d, y_rem_d, cw_d, ch_d;
    logic [18:0] row_base_d, setup_pix_d;
    logic        degen_d;
    logic        last_col_d, last_pix_d;
    logic [9:0]  next_col_d;
    logic [18:0] next_row_base_d, next_pix_d;

    assign reg_wr = cpu_w_en && (cpu_waddr[31:28] == REG_REGION);
    assign fb_wr  = cpu_w_en && (cpu_waddr[31:28] == FB_REGION);
    assign start  = reg_wr && (cpu_waddr[4:2] == 3'd5);

    assign busy      = (state_q != S_IDLE);
    assign cpu_stall = fb_wr && busy;
    assign done      = done_q;
    assign fb_w_en   = fb_w_en_q;
    assign fb_data   = fb_data_q;
    assign fb_waddr  = fb_waddr_q;

    // Address bits above the pixel index, the byte offset and upper data bits carry no meaning here
    wire unused_bits = &{1'b0, cpu_data[31:10], cpu_waddr[27:19], cpu_waddr[1:0]};

    // Setup-time clipping and row base (Y0*640 as two shifts, valid for the 640-wide frame)
    always_comb begin
        x_rem_d     = H_RES_W - x0_q;
        y_rem_d     = V_RES_W - y0_q;
        cw_d        = (w_q < x_rem_d) ? w_q : x_rem_d;
        ch_d        = (h_q < y_rem_d) ? h_q : y_rem_d;
        row_base_d  = {y0_q, 9'b0} + {2'b0, y0_q, 7'b0};
        setup_pix_d = row_base_d + {9'b0, x0_q};
        degen_d     = (x0_q >= H_RES_W) || (y0_q >= V_RES_W) ||
                      (w_q == 10'd0) || (h_q == 10'd0);
    end

    // Raster stepping: address of the pixel following the one currently on the bus
    always_comb begin
        last_col_d      = (col_q == cw_q - 10'd1);
        last_pix_d      = last_col_d && (row_q == ch_q - 10'd1);
        next_col_d      = last_col_d ? 10'd0 : col_q + 10'd1;
        next_row_base_d = last_col_d ? row_base_q + H_RES_A : row_base_q;
        next_pix_d      = next_row_base_d + {9'b0, fx0_q} + {9'b0, next_col_d};
    end

    // Register file, writable in any state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x0_q     <= '0;
            y0_q     <= '0;
            w_q      <= '0;
            h_q      <= '0;
            colour_q <= '0;
        end else if (reg_wr) begin
            case (cpu_waddr[4:2])
                3'd0:    x0_q     <= cpu_data[9:0];
                3'd1:    y0_q     <= cpu_data[9:0];
                3'd2:    w_q      <= cpu_data[9:0];
                3'd3:    h_q      <= cpu_data[9:0];
                3'd4:    colour_q <= cpu_data[7:0];
                default: ;
            endcase
        end
    end

    // Fill sequencer with registered framebuffer port and done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            fx0_q      <= '0;
            cw_q       <= '0;
            ch_q       <= '0;
            col_q      <= '0;
            row_q      <= '0;
            row_base_q <= '0;
            done_q     <= 1'b0;
            fb_w_en_q  <= 1'b0;
            fb_data_q  <= '0;
            fb_waddr_q <= '0;
        end else begin
            done_q    <= 1'b0;
            fb_w_en_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_SETUP;
                    end else if (fb_wr) begin
                        fb_w_en_q  <= 1'b1;
                        fb_waddr_q <= {FB_REGION, 9'b0, cpu_waddr[18:0]};
                        fb_data_q  <= {24'b0, cpu_data[7:0]};
                    end
                end
                S_SETUP: begin
                    fx0_q      <= x0_q;
                    cw_q       <= cw_d;
                    ch_q       <= ch_d;
                    row_base_q <= row_base_d;
                    col_q      <= '0;
                    row_q      <= '0;
                    if (degen_d) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q    <= S_FILL;
                        fb_w_en_q  <= 1'b1;
                        fb_waddr_q <= {FB_REGION, 9'b0, setup_pix_d};
                        fb_data_q  <= {24'b0, colour_q};
                    end
                end
                S_FILL: begin
                    if (last_pix_d) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        fb_w_en_q  <= 1'b1;
                        fb_waddr_q <= {FB_REGION, 9'b0, next_pix_d};
                        col_q      <= next_col_d;
                        row_base_q <= next_row_base_d;
                        if (last_col_d) begin
                            row_q <= row_q + 10'd1;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/fb_rect_fill.md
Name: fb_rect_fill

Overview:
- MMIO-programmed rectangle-fill engine that sits directly upstream of display_module and drives its data/waddr/w_en write port.
- The CPU programs origin, size and colour, then starts a fill; the engine emits one framebuffer pixel write per clock.
- When idle, CPU writes to the framebuffer region pass through, registered one cycle. While busy, those writes are stalled.

Parameters:
- H_RES, 640, framebuffer width in pixels
- V_RES, 480, framebuffer height in pixels
- FB_REGION, 4'b0001, waddr[31:28] tag of the framebuffer region
- REG_REGION, 4'b0010, waddr[31:28] tag of this block's registers

Ports:
- clk  in  1  system clock, single domain
- rst  in  1  reset, asynchronous, active-high
- cpu_data  in  32  CPU write data
- cpu_waddr  in  32  CPU write address
- cpu_w_en  in  1  CPU write strobe, one cycle per write
- cpu_stall  out  1  combinational; high when cpu_w_en is high, cpu_waddr[31:28]==FB_REGION, and the engine is not IDLE
- busy  out  1  high in SETUP/FILL/DONE
- done  out  1  one-cycle pulse when a fill completes
- fb_data  out  32  {24'b0, colour}, drives display_module data
- fb_waddr  out  32  {FB_REGION, 9'b0, pixel_addr[18:0]}
- fb_w_en  out  1  write strobe to display_module

Behaviour:
- Reset (async, rst=1):
  - fb_w_en=0, fb_data=0, fb_waddr=0, done=0, busy=0.
  - State IDLE; all registers cleared.
  - Asserting rst mid-fill aborts the fill immediately; no further writes are issued.
- Registers: written when cpu_w_en and cpu_waddr[31:28]==REG_REGION, decoded on cpu_waddr[4:2]:
  - 0 X0[9:0]
  - 1 Y0[9:0]
  - 2 W[9:0]
  - 3 H[9:0]
  - 4 COLOUR[7:0]
  - 5 CTRL (any write = start)
  - Other offsets are ignored.
- Register writes are accepted in any state. The running fill uses copies latched in SETUP, so writes during a fill do not affect it.
- Start is honoured only in IDLE; a start while busy is dropped.
- State machine:
  - IDLE: on start -> SETUP.
  - SETUP (1 cycle):
    - Latch colour.
    - cw = min(W, H_RES-X0); ch = min(H, V_RES-Y0).
    - row_base = Y0*H_RES, computed shift-add as (Y0<<9)+(Y0<<7); no multiplier.
    - If X0>=H_RES, Y0>=V_RES, W==0 or H==0 -> DONE; else -> FILL.
  - FILL:
    - One write per cycle, fb_w_en=1, pixel_addr = row_base + X0 + col.
    - col increments; at col==cw-1 it wraps to 0, row_base += H_RES and row increments.
    - After the write with row==ch-1 and col==cw-1 -> DONE.
    - Writes are contiguous: exactly cw*ch cycles of fb_w_en with no gaps.
  - DONE (1 cycle): done=1, fb_w_en=0 -> IDLE.
- Latency:
  - Start write seen at edge t: SETUP in cycle t+1, first fb_w_en in cycle t+2.
  - done pulses in the cycle after the last write.
  - Degenerate fill: done in cycle t+2.
- Passthrough (IDLE only): a CPU write to FB_REGION is registered to the fb outputs one cycle later.
  - fb_waddr = {FB_REGION, 9'b0, cpu_waddr[18:0]}; fb_data = {24'b0, cpu_data[7:0]}; fb_w_en=1 for one cycle.
  - Start and passthrough in the same cycle cannot occur (one CPU write per cycle).
- Stall: while busy, FB-region CPU writes are not forwarded. The CPU must hold them until cpu_stall drops. Register-region writes never stall.
- Widths: internal pixel_addr is 19 bits; the maximum 307199 fits, so there is no overflow.

Test Plan:
- Basic fill: X0=1, Y0=1, W=2, H=2, COLOUR=0xAB, start -> fb_w_en on 4 consecutive cycles from t+2 at addrs 641, 642, 1281, 1282 with fb_data=0xAB; done one cycle later; busy low after.
- Clip: X0=638, Y0=479, W=5, H=3 -> exactly 2 writes, at 307198 and 307199; done.
- Degenerate: W=0 (separately X0=700) -> no fb_w_en; done pulses at t+2.
- Passthrough: idle, CPU writes 0x1000_0005 with data 0x0000_003C -> next cycle fb_w_en=1, fb_waddr=0x1000_0005, fb_data=0x3C; cpu_stall stays 0.
- Busy: during a 10x10 fill, issue an FB write and a start -> cpu_stall=1 while held, the start is dropped, exactly 100 fill writes occur, and the stalled write is emitted after return to IDLE.
- Reset mid-fill: assert rst at the 5th write of a 4x4 fill -> fb_w_en=0 at once, busy=0, no done pulse; a new start afterwards fills normally.
